// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation encodings and the
// decoded-entry record carried from the decode stage to execute.
package decode_pkg;

    localparam int NPC_ADDR_BUS = 32;
    localparam int NPC_DATA_BUS = 32;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [3:0] ALU_ADD      = 4'd0;
    localparam logic [3:0] ALU_SUB      = 4'd1;
    localparam logic [3:0] ALU_SLL      = 4'd2;
    localparam logic [3:0] ALU_SLT      = 4'd3;
    localparam logic [3:0] ALU_SLTU     = 4'd4;
    localparam logic [3:0] ALU_XOR      = 4'd5;
    localparam logic [3:0] ALU_SRL      = 4'd6;
    localparam logic [3:0] ALU_SRA      = 4'd7;
    localparam logic [3:0] ALU_OR       = 4'd8;
    localparam logic [3:0] ALU_AND      = 4'd9;
    localparam logic [3:0] ALU_LUI_PASS = 4'd10;

    localparam logic [NPC_DATA_BUS-1:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [NPC_DATA_BUS-1:0] INST_NOP    = 32'h0000_0013;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        src2_imm;
        logic        src1_pc;
        logic        wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jump;
        logic        csr;
        logic        ebreak;
        logic        illegal;
    } dec_t;

    // alt selects SUB/SRA (instruction bit 30) for the funct3 codes that have one.
    function automatic logic [3:0] alu_op_for(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_controller.sv
// Single-entry EMPTY/FULL handshake controller for the decode pipeline register;
// load_o tells the datapath when to capture a new decoded entry.
module decode_controller
    import decode_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic flush_i,
    input  logic valid_pre_i,
    input  logic ready_post_i,
    output logic ready_pre_o,
    output logic valid_post_o,
    output logic load_o
);

    state_e state_q;
    state_e state_d;
    logic   fire_pre;
    logic   fire_post;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        valid_post_o = (state_q == ST_FULL);
        ready_pre_o  = (state_q == ST_EMPTY) | ready_post_i;
        fire_pre     = valid_pre_i & ready_pre_o;
        fire_post    = valid_post_o & ready_post_i;
        state_d      = state_q;
        case (state_q)
            ST_EMPTY: if (fire_pre) state_d = ST_FULL;
            ST_FULL:  if (fire_post && !fire_pre) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        // A redirect drops both the held entry and anything accepted this cycle.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
        load_o = fire_pre & ~flush_i;
    end

endmodule

// File: rtl/decode.sv
// RV32I instruction decode stage: combinational field/immediate decode of the
// fetched word, captured into a single-entry register toward execute.
module decode
    import decode_pkg::*;
#(
    parameter bit                      RV32E    = 1'b0,
    parameter logic [NPC_ADDR_BUS-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    valid_pre_i,
    output logic                    ready_pre_o,
    input  logic [NPC_ADDR_BUS-1:0] pc_i,
    input  logic [NPC_DATA_BUS-1:0] inst_i,
    output logic                    valid_post_o,
    input  logic                    ready_post_i,
    output logic [NPC_ADDR_BUS-1:0] pc_o,
    output logic [NPC_DATA_BUS-1:0] inst_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [4:0]              rd_o,
    output logic [31:0]             imm_o,
    output logic [3:0]              alu_op_o,
    output logic                    src2_imm_o,
    output logic                    src1_pc_o,
    output logic                    wen_o,
    output logic                    mem_ren_o,
    output logic                    mem_wen_o,
    output logic [2:0]              mem_size_o,
    output logic                    branch_o,
    output logic                    jump_o,
    output logic                    csr_o,
    output logic                    ebreak_o,
    output logic                    illegal_o
);

    logic                    load;
    logic [NPC_ADDR_BUS-1:0] pc_q;
    logic [NPC_DATA_BUS-1:0] inst_q;
    dec_t                    dec_q;
    dec_t                    dec_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        bad;

    decode_controller u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (flush_i),
        .valid_pre_i  (valid_pre_i),
        .ready_post_i (ready_post_i),
        .ready_pre_o  (ready_pre_o),
        .valid_post_o (valid_post_o),
        .load_o       (load)
    );

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        dec_d   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OPCODE_LUI: begin
                use_rd          = 1'b1;
                dec_d.imm       = imm_u;
                dec_d.alu_op    = ALU_LUI_PASS;
                dec_d.src2_imm  = 1'b1;
            end
            OPCODE_AUIPC: begin
                use_rd          = 1'b1;
                dec_d.imm       = imm_u;
                dec_d.src1_pc   = 1'b1;
                dec_d.src2_imm  = 1'b1;
            end
            OPCODE_JAL: begin
                use_rd          = 1'b1;
                dec_d.imm       = imm_j;
                dec_d.src1_pc   = 1'b1;
                dec_d.jump      = 1'b1;
            end
            OPCODE_JALR: begin
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                dec_d.imm       = imm_i;
                dec_d.src1_pc   = 1'b1;
                dec_d.jump      = 1'b1;
            end
            OPCODE_BRANCH: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec_d.imm       = imm_b;
                dec_d.alu_op    = ALU_SUB;
                dec_d.branch    = 1'b1;
            end
            OPCODE_LOAD: begin
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                dec_d.imm       = imm_i;
                dec_d.src2_imm  = 1'b1;
                dec_d.mem_ren   = 1'b1;
                dec_d.mem_size  = funct3;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPCODE_STORE: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec_d.imm       = imm_s;
                dec_d.src2_imm  = 1'b1;
                dec_d.mem_wen   = 1'b1;
                dec_d.mem_size  = funct3;
                bad = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPCODE_OP_IMM: begin
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                dec_d.imm       = imm_i;
                dec_d.src2_imm  = 1'b1;
                // Only the right shift uses bit 30 as a selector; ADDI never becomes SUB.
                dec_d.alu_op    = alu_op_for(funct3, (funct3 == 3'b101) & inst_i[30]);
                if (funct3 == 3'b001) begin
                    bad = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OPCODE_OP: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                use_rd          = 1'b1;
                dec_d.alu_op    = alu_op_for(funct3, inst_i[30]);
                if (funct7 == 7'b0100000) begin
                    bad = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else begin
                    bad = (funct7 != 7'b0000000);
                end
            end
            OPCODE_MISC_MEM: begin
            end
            OPCODE_SYSTEM: begin
                use_rs1         = 1'b1;
                use_rd          = (funct3 != 3'b000);
                dec_d.imm       = imm_i;
                dec_d.csr       = (inst_i != INST_EBREAK);
                dec_d.ebreak    = (inst_i == INST_EBREAK);
            end
            default: bad = 1'b1;
        endcase

        dec_d.rs1 = use_rs1 ? inst_i[19:15] : 5'd0;
        dec_d.rs2 = use_rs2 ? inst_i[24:20] : 5'd0;
        dec_d.rd  = use_rd  ? inst_i[11:7]  : 5'd0;
        if (RV32E && (dec_d.rs1[4] || dec_d.rs2[4] || dec_d.rd[4])) begin
            bad = 1'b1;
        end
        dec_d.illegal = bad;
        dec_d.wen     = use_rd & (dec_d.rd != 5'd0) & ~bad;
        dec_d.mem_ren = dec_d.mem_ren & ~bad;
        dec_d.mem_wen = dec_d.mem_wen & ~bad;
    end

    // Outputs deliberately hold their last value when the stage empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            inst_q <= INST_NOP;
            dec_q  <= '0;
        end else if (load) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
            dec_q  <= dec_d;
        end
    end

    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign rs1_o      = dec_q.rs1;
    assign rs2_o      = dec_q.rs2;
    assign rd_o       = dec_q.rd;
    assign imm_o      = dec_q.imm;
    assign alu_op_o   = dec_q.alu_op;
    assign src2_imm_o = dec_q.src2_imm;
    assign src1_pc_o  = dec_q.src1_pc;
    assign wen_o      = dec_q.wen;
    assign mem_ren_o  = dec_q.mem_ren;
    assign mem_wen_o  = dec_q.mem_wen;
    assign mem_size_o = dec_q.mem_size;
    assign branch_o   = dec_q.branch;
    assign jump_o     = dec_q.jump;
    assign csr_o      = dec_q.csr;
    assign ebreak_o   = dec_q.ebreak;
    assign illegal_o  = dec_q.illegal;

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction decode stage; sits directly downstream of the fetch stage and upstream of the execute stage.
- Accepts one {pc, inst} pair from fetch through a valid/ready handshake.
- Decodes the RV32I base instruction into register indices, a sign-extended immediate and control fields, and holds the result in a single-entry pipeline register until execute accepts it.
- Supports flush on redirect (branch/exception).

Parameters:
- RV32E, 0, when 1 any rs1/rs2/rd index >= 16 raises illegal_o
- RESET_PC, 32'h8000_0000, value of pc_o after reset

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- flush_i  input  1  discard held/incoming instruction (redirect)
- valid_pre_i  input  1  fetch has a valid {pc, inst}
- ready_pre_o  output  1  decode can accept this cycle
- pc_i  input  32  fetch pc
- inst_i  input  32  fetch instruction
- valid_post_o  output  1  decoded entry valid toward execute
- ready_post_i  input  1  execute accepts this cycle
- pc_o  output  32  registered pc
- inst_o  output  32  registered raw instruction
- rs1_o / rs2_o / rd_o  output  5 each  register indices (0 when unused)
- imm_o  output  32  sign-extended immediate
- alu_op_o  output  4  ALU operation code (`ALU_* encodings)
- src2_imm_o  output  1  ALU operand 2 is imm, else rs2
- src1_pc_o  output  1  ALU operand 1 is pc (AUIPC/JAL/JALR link)
- wen_o  output  1  register write enable (forced 0 when rd==0)
- mem_ren_o / mem_wen_o  output  1 each  load / store
- mem_size_o  output  3  funct3 of load/store
- branch_o  output  1  conditional branch; funct3 carried in inst_o
- jump_o  output  1  JAL or JALR
- csr_o  output  1  SYSTEM/CSR class (ecall, mret, csrr*)
- ebreak_o  output  1  ebreak (simulation stop)
- illegal_o  output  1  unrecognised opcode/funct

Behaviour:
- Two-state controller: EMPTY, FULL.
  - valid_post_o = (state == FULL).
  - ready_pre_o = (state == EMPTY) | ready_post_i. This is a combinational pass-through of ready_post_i.
- fire_pre = valid_pre_i & ready_pre_o.
- fire_post = valid_post_o & ready_post_i.
- Transitions:
  - EMPTY -> FULL on fire_pre.
  - FULL -> EMPTY on fire_post & ~fire_pre.
  - FULL stays FULL on fire_post & fire_pre. This is back-to-back: new entry replaces old in the same cycle, so throughput is 1 inst/cycle.
  - FULL stays FULL while ~ready_post_i. All outputs are held stable.
- Data path: decode is combinational from inst_i. All decoded outputs are registered on fire_pre, so latency is 1 cycle from fire_pre to valid_post_o.
- Immediate formats:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type: imm_o = 0.
- Unused register fields are output as 0:
  - LUI/AUIPC/JAL: rs1 = 0.
  - Only R/S/B types drive rs2.
  - S/B types: rd = 0, wen = 0.
- illegal_o:
  - Set when opcode is not among the RV32I opcodes.
  - Set on bad funct3/funct7 for OP/OP-IMM shifts, or bad load/store size.
  - Set on index >= 16 when RV32E = 1.
  - When illegal_o = 1: wen_o, mem_ren_o and mem_wen_o are all forced to 0.
- ebreak_o: inst == 32'h0010_0073. ebreak also sets csr_o = 0.
- flush_i:
  - Has priority over everything; next state is EMPTY.
  - Any fire_pre in the same cycle is dropped (ready_pre_o still follows the formula; the accepted data is discarded).
  - fire_post in the same cycle still counts as consumed by execute.
- Reset:
  - state = EMPTY, valid_post_o = 0.
  - pc_o = RESET_PC.
  - inst_o = 32'h0000_0013 (NOP).
  - All other outputs 0.
  - Reset mid-operation discards the held entry.
- Outputs are not meaningful when valid_post_o = 0. They hold their last value; they are not cleared.

Decomposition:
- Into the shared defines.v:
  - RV32I opcode constants (`OPCODE_LUI ... `OPCODE_SYSTEM).
  - `ALU_* 4-bit encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI_PASS).
  - `INST_EBREAK constant.
  - `NPC_ADDR_BUS / `NPC_DATA_BUS widths.
- One sub-module, decode_controller: the EMPTY/FULL FSM generating valid_post_o, ready_pre_o and the register write enable.
- Field extraction and immediate generation stay in the top module.

Test Plan:
- Reset, then feed addi x1,x0,5 (32'h0050_0093) at pc 0x8000_0000 with ready_post_i = 1. Required one cycle later:
  - valid_post_o = 1, rd_o = 1, rs1_o = 0.
  - imm_o = 5, alu_op_o = ADD, src2_imm_o = 1, wen_o = 1.
- Stream 3 instructions on consecutive cycles with ready_post_i = 1 -> 3 consecutive valid_post_o beats, with ready_pre_o held at 1 throughout.
- Hold ready_post_i = 0 for 4 cycles with the stage FULL:
  - ready_pre_o = 0.
  - All outputs unchanged.
  - When ready_post_i is released, the pending input is accepted on the same cycle.
- Branch beq x1,x2,-4 (32'hFE20_8EE3) -> branch_o = 1, imm_o = 32'hFFFF_FFFC, wen_o = 0, rd_o = 0. Store sw x2,8(x1) -> mem_wen_o = 1, mem_size_o = 3'b010, imm_o = 8.
- Assert flush_i while FULL together with a valid_pre_i -> next cycle valid_post_o = 0; the flushed instruction never appears.
- Illegal/special encodings:
  - 32'h0000_0000 -> illegal_o = 1, wen_o = 0.
  - 32'h0010_0073 -> ebreak_o = 1.
  - RV32E = 1 with add x16,x1,x2 -> illegal_o = 1.
